// File: rtl/p4_router_pkg.sv
// Shared types and constants for the P4 router ingress path.
package p4_router_pkg;

  // Packet byte-length width; 11 bits covers a 1500 B MTU.
  localparam int PKT_LEN_WIDTH = 11;

  // Ingress scheduler FSM states.
  typedef enum logic [1:0] {
    SCAN,
    OFFER,
    BUSY
  } ing_sched_state_t;

endpackage

// File: rtl/p4_router_ingress_scheduler.sv
// Deficit-weighted round-robin scheduler over the ingress buffer partitions.
// One port is evaluated per SCAN cycle. A selected packet is offered to the
// read controller (OFFER) and tracked until it has been dispatched (BUSY).
module p4_router_ingress_scheduler
  import p4_router_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int QUANTUM_WIDTH = 16,
  parameter int LEN_WIDTH     = PKT_LEN_WIDTH,
  parameter int DEFICIT_WIDTH = 17,
  localparam int PORT_W       = $clog2(NUM_PORTS)
) (
  input  logic                     clk,
  input  logic                     sresetn,
  input  logic [QUANTUM_WIDTH-1:0] quantum [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]     pkt_avail,
  input  logic [LEN_WIDTH-1:0]     head_len [NUM_PORTS],
  output logic                     grant_valid,
  output logic [PORT_W-1:0]        grant_port,
  output logic [LEN_WIDTH-1:0]     grant_len,
  input  logic                     grant_ready,
  input  logic                     pkt_done,
  output logic                     sched_err
);

  localparam logic [DEFICIT_WIDTH-1:0] DEFICIT_MAX = '1;
  localparam logic [PORT_W-1:0]        LAST_PORT   = PORT_W'(NUM_PORTS - 1);

  // Deficit plus quantum, clamped at the counter's maximum value.
  function automatic logic [DEFICIT_WIDTH-1:0] sat_add(
    input logic [DEFICIT_WIDTH-1:0] a,
    input logic [QUANTUM_WIDTH-1:0] b
  );
    logic [DEFICIT_WIDTH:0] sum;
    sum = {1'b0, a} + (DEFICIT_WIDTH + 1)'(b);
    return sum[DEFICIT_WIDTH] ? DEFICIT_MAX : sum[DEFICIT_WIDTH-1:0];
  endfunction

  ing_sched_state_t         state, state_nxt;
  logic [PORT_W-1:0]        cur_port, cur_port_nxt, next_port;
  logic                     new_turn, new_turn_nxt;
  logic [DEFICIT_WIDTH-1:0] deficit [NUM_PORTS];
  logic [DEFICIT_WIDTH-1:0] eff, head_ext, def_wdata;
  logic                     def_we, grant_load, err_nxt;

  // Quantum is folded in only on the first look at a port in a turn, so a
  // quantum change mid-turn takes effect from the following turn.
  assign eff       = new_turn ? sat_add(deficit[cur_port], quantum[cur_port])
                              : deficit[cur_port];
  assign head_ext  = DEFICIT_WIDTH'(head_len[cur_port]);
  assign next_port = (cur_port == LAST_PORT) ? '0 : cur_port + PORT_W'(1);

  // A handshake strobe in the wrong state is ignored but flagged.
  assign err_nxt = (pkt_done && state != BUSY) || (grant_ready && state != OFFER);

  // Next-state, scan bookkeeping and grant output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_nxt    = state;
    cur_port_nxt = cur_port;
    new_turn_nxt = new_turn;
    def_we       = 1'b0;
    def_wdata    = eff;
    grant_load   = 1'b0;
    grant_valid  = 1'b0;
    case (state)
      SCAN: begin
        def_we = 1'b1;
        if (!pkt_avail[cur_port]) begin
          // An empty partition forfeits its accumulated credit.
          def_wdata    = '0;
          cur_port_nxt = next_port;
          new_turn_nxt = 1'b1;
        end else if (head_ext <= eff) begin
          def_wdata    = eff - head_ext;
          new_turn_nxt = 1'b0;
          grant_load   = 1'b1;
          state_nxt    = OFFER;
        end else begin
          // Head packet too large: bank the credit and move on.
          def_wdata    = eff;
          cur_port_nxt = next_port;
          new_turn_nxt = 1'b1;
        end
      end
      OFFER: begin
        grant_valid = 1'b1;
        if (grant_ready) state_nxt = BUSY;
      end
      BUSY: begin
        // Stay on the same port so it can spend its remaining deficit.
        if (pkt_done) begin
          state_nxt    = SCAN;
          new_turn_nxt = 1'b0;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // State, deficit and grant registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (!sresetn) begin
      state      <= SCAN;
      cur_port   <= '0;
      new_turn   <= 1'b1;
      grant_port <= '0;
      grant_len  <= '0;
      sched_err  <= 1'b0;
      // NOTE: the deficit array is reset explicitly; stale credit after a
      // reset would skew fairness, so it cannot be left uninitialised.
      for (int p = 0; p < NUM_PORTS; p++) deficit[p] <= '0;
    end else begin
      state     <= state_nxt;
      cur_port  <= cur_port_nxt;
      new_turn  <= new_turn_nxt;
      sched_err <= err_nxt;
      if (def_we) deficit[cur_port] <= def_wdata;
      if (grant_load) begin
        grant_port <= cur_port;
        grant_len  <= head_len[cur_port];
      end
    end
  end

endmodule

// File: tb/tb_p4_router_ingress_scheduler.sv
// Self-checking bench for p4_router_ingress_scheduler: directed scenarios
// followed by randomized traffic, checked against a transaction-level DWRR
// model that predicts which port wins and after how many scan cycles.
module tb_p4_router_ingress_scheduler;

  localparam int NP = 4;
  localparam int QW = 16;
  localparam int LW = 11;
  localparam int DW = 17;
  localparam longint DEF_MAX = (64'd1 << DW) - 1;

  logic          clk = 1'b0;
  logic          sresetn = 1'b0;
  logic [QW-1:0] quantum [NP];
  logic [NP-1:0] pkt_avail = '0;
  logic [LW-1:0] head_len [NP];
  logic          grant_valid;
  logic [1:0]    grant_port;
  logic [LW-1:0] grant_len;
  logic          grant_ready = 1'b0;
  logic          pkt_done = 1'b0;
  logic          sched_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  longint m_def [NP];
  int     m_cur;
  bit     m_new;
  int     g_port, g_len;

  p4_router_ingress_scheduler #(
    .NUM_PORTS(NP), .QUANTUM_WIDTH(QW), .LEN_WIDTH(LW), .DEFICIT_WIDTH(DW)
  ) dut (
    .clk(clk), .sresetn(sresetn), .quantum(quantum), .pkt_avail(pkt_avail),
    .head_len(head_len), .grant_valid(grant_valid), .grant_port(grant_port),
    .grant_len(grant_len), .grant_ready(grant_ready), .pkt_done(pkt_done),
    .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int p = 0; p < NP; p++) m_def[p] = 0;
    m_cur = 0;
    m_new = 1'b1;
  endtask

  // Walk the round-robin for up to budget scan opportunities using the
  // current inputs; c is the opportunity that wins (0 if none does).
  task automatic m_scan(input int budget, output int c, output int gp, output int gl);
    int     p;
    longint eff;
    c = 0; gp = 0; gl = 0;
    for (int k = 1; k <= budget; k++) begin
      p   = m_cur;
      eff = m_new ? m_def[p] + longint'(quantum[p]) : m_def[p];
      if (eff > DEF_MAX) eff = DEF_MAX;
      if (!pkt_avail[p]) begin
        m_def[p] = 0;
        m_cur    = (p + 1) % NP;
        m_new    = 1'b1;
      end else if (longint'(head_len[p]) <= eff) begin
        m_def[p] = eff - longint'(head_len[p]);
        m_new    = 1'b0;
        c = k; gp = p; gl = int'(head_len[p]);
        return;
      end else begin
        m_def[p] = eff;
        m_cur    = (p + 1) % NP;
        m_new    = 1'b1;
      end
    end
  endtask

  task automatic check_deficits(input string tag);
    for (int p = 0; p < NP; p++)
      check($sformatf("%s deficit[%0d]", tag, p), 64'(dut.deficit[p]), 64'(m_def[p]));
  endtask

  // From just after a SCAN-entry edge, wait for the predicted grant (or
  // confirm none appears within the budget) and check it.
  task automatic expect_grant(input string tag, input int budget, output bit got);
    int c, gp, gl, n;
    m_scan(budget, c, gp, gl);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant_valid !== 1'b1 && n < budget);
    if (c == 0) begin
      got = 1'b0;
      check({tag, " no grant"}, 64'(grant_valid), 64'd0);
    end else begin
      got    = 1'b1;
      g_port = gp;
      g_len  = gl;
      check({tag, " latency"}, 64'(n), 64'(c));
      check({tag, " valid"}, 64'(grant_valid), 64'd1);
      check({tag, " port"}, 64'(grant_port), 64'(gp));
      check({tag, " len"}, 64'(grant_len), 64'(gl));
    end
    check_deficits(tag);
  endtask

  // Hold off acceptance, accept, then signal dispatch after done_delay.
  task automatic handshake(input string tag, input int ready_delay, input int done_delay);
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      check({tag, " hold valid"}, 64'(grant_valid), 64'd1);
      check({tag, " hold port"}, 64'(grant_port), 64'(g_port));
      check({tag, " hold len"}, 64'(grant_len), 64'(g_len));
    end
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check({tag, " valid after accept"}, 64'(grant_valid), 64'd0);
    for (int i = 0; i < done_delay; i++) tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    check({tag, " no err"}, 64'(sched_err), 64'd0);
  endtask

  // Idle scan cycles with no grant expected.
  task automatic idle(input string tag, input int n);
    int c, gp, gl;
    for (int i = 0; i < n; i++) begin
      m_scan(1, c, gp, gl);
      tick();
    end
    check({tag, " idle valid"}, 64'(grant_valid), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    sresetn = 1'b0;
    grant_ready = 1'b0;
    pkt_done = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    m_reset();
    sresetn = 1'b1;
  endtask

  initial begin
    bit got;
    for (int p = 0; p < NP; p++) begin
      quantum[p]  = 16'd1500;
      head_len[p] = '0;
    end
    m_reset();
    tick(); tick(); tick();

    // Reset state.
    check("rst valid", 64'(grant_valid), 64'd0);
    check("rst port", 64'(grant_port), 64'd0);
    check("rst len", 64'(grant_len), 64'd0);
    check("rst err", 64'(sched_err), 64'd0);
    check_deficits("rst");

    // First grant after release: ports 0 and 1 scanned empty, port 2 wins.
    pkt_avail   = 4'b0100;
    head_len[2] = 11'd64;
    sresetn     = 1'b1;
    expect_grant("first", 20, got);
    check("first deficit2 const", 64'(dut.deficit[2]), 64'd1436);
    pkt_avail = 4'b0000;
    handshake("first", 10, 1);

    // pkt_done and grant_ready strobes while scanning.
    pkt_done = 1'b1;
    idle("stray done", 1);
    pkt_done = 1'b0;
    check("stray done err", 64'(sched_err), 64'd1);
    idle("stray done", 1);
    check("stray done err clr", 64'(sched_err), 64'd0);
    grant_ready = 1'b1;
    idle("stray ready", 1);
    grant_ready = 1'b0;
    check("stray ready err", 64'(sched_err), 64'd1);
    idle("stray ready", 1);
    check("stray ready err clr", 64'(sched_err), 64'd0);
    check_deficits("stray");

    // Head larger than one quantum: waits a turn, then granted.
    do_reset(1);
    quantum[0]  = 16'd1000;
    pkt_avail   = 4'b0001;
    head_len[0] = 11'd1500;
    expect_grant("two turns", 20, got);
    check("two turns latency const", 64'(got), 64'd1);
    check("two turns deficit0 const", 64'(dut.deficit[0]), 64'd500);
    handshake("two turns", 0, 0);
    quantum[0] = 16'd1500;

    // Small packets drain one quantum: 23 grants, 28 bytes left over.
    do_reset(1);
    pkt_avail   = 4'b0010;
    head_len[1] = 11'd64;
    for (int i = 0; i < 23; i++) begin
      expect_grant("burst", 20, got);
      handshake("burst", 0, 2);
    end
    check("burst deficit1 const", 64'(dut.deficit[1]), 64'd28);
    expect_grant("burst new turn", 20, got);
    check("burst new turn deficit1 const", 64'(dut.deficit[1]), 64'd1464);
    handshake("burst new turn", 0, 2);

    // Credit is dropped when the port is found empty.
    do_reset(1);
    pkt_avail   = 4'b1000;
    head_len[3] = 11'd1000;
    expect_grant("drain", 20, got);
    check("drain deficit3 const", 64'(dut.deficit[3]), 64'd500);
    pkt_avail = 4'b0000;
    handshake("drain", 0, 1);
    idle("drain", 1);
    check("drain deficit3 cleared", 64'(dut.deficit[3]), 64'd0);

    // Zero quantum never earns a grant.
    quantum[0]  = 16'd0;
    pkt_avail   = 4'b0001;
    head_len[0] = 11'd64;
    expect_grant("zero quantum", 40, got);
    check("zero quantum deficit0 const", 64'(dut.deficit[0]), 64'd0);
    quantum[0] = 16'd1500;

    // Reset while BUSY drops the grant; scanning restarts at port 0.
    do_reset(1);
    pkt_avail   = 4'b0100;
    head_len[2] = 11'd64;
    expect_grant("busy rst pre", 20, got);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    sresetn = 1'b0;
    tick();
    m_reset();
    check("busy rst valid", 64'(grant_valid), 64'd0);
    check("busy rst port", 64'(grant_port), 64'd0);
    check("busy rst len", 64'(grant_len), 64'd0);
    check("busy rst err", 64'(sched_err), 64'd0);
    check_deficits("busy rst");
    sresetn = 1'b1;
    expect_grant("busy rst post", 20, got);
    check("busy rst post deficit2 const", 64'(dut.deficit[2]), 64'd1436);
    handshake("busy rst post", 0, 0);

    // Randomized traffic against the model.
    do_reset(1);
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < NP; p++) begin
        quantum[p]  = QW'($urandom_range(0, 1600));
        head_len[p] = LW'($urandom_range(1, 1500));
      end
      pkt_avail = NP'($urandom_range(0, (1 << NP) - 1));
      expect_grant($sformatf("rand%0d", it), 40, got);
      if (got) handshake($sformatf("rand%0d", it), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/p4_router_ingress_scheduler.md
P4_ROUTER_INGRESS_SCHEDULER -- requirements
Module: p4_router_ingress_scheduler

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of ingress buffer partitions served; SHALL be >= 2.
REQ-002 Parameter QUANTUM_WIDTH, default 16, per-port quantum width in bytes.
REQ-003 Parameter LEN_WIDTH, default 11, packet byte-length width (covers 1500 B MTU).
REQ-004 Parameter DEFICIT_WIDTH, default 17, deficit counter width; SHALL be > max(QUANTUM_WIDTH, LEN_WIDTH).
REQ-005 Port clk, input, 1, the only clock; all logic on rising edge.
REQ-006 Port sresetn, input, 1, reset; synchronous, active-low.
REQ-007 Port quantum[NUM_PORTS], input, QUANTUM_WIDTH each, per-port DWRR quantum in bytes.
REQ-008 Port pkt_avail, input, NUM_PORTS, bit p = partition p holds at least one complete packet.
REQ-009 Port head_len[NUM_PORTS], input, LEN_WIDTH each, byte length of the head packet of partition p; valid when pkt_avail[p]=1.
REQ-010 Port grant_valid, output, 1, a grant is offered.
REQ-011 Port grant_port, output, $clog2(NUM_PORTS), granted partition index.
REQ-012 Port grant_len, output, LEN_WIDTH, byte length of the granted packet.
REQ-013 Port grant_ready, input, 1, read controller accepts the grant.
REQ-014 Port pkt_done, input, 1, single-cycle pulse: granted packet fully dispatched (tlast accepted).
REQ-015 Port sched_err, output, 1, single-cycle pulse on protocol violation.

Function
REQ-016 States SCAN, OFFER and BUSY; registers cur_port, new_turn and deficit[NUM_PORTS].
REQ-017 In SCAN, one port (cur_port) SHALL be evaluated per cycle, with eff = new_turn ? sat(deficit[cur]+quantum[cur]) : deficit[cur], where sat clamps to 2^DEFICIT_WIDTH-1.
REQ-018 In SCAN with pkt_avail[cur]=0: deficit[cur]<=0, cur_port<=next, new_turn<=1.
REQ-019 In SCAN with pkt_avail[cur]=1 and head_len[cur]<=eff: grant_port<=cur, grant_len<=head_len[cur], deficit[cur]<=eff-head_len[cur], new_turn<=0, state<=OFFER.
REQ-020 In SCAN with pkt_avail[cur]=1 and head_len[cur]>eff: deficit[cur]<=eff, cur_port<=next, new_turn<=1.
REQ-021 next SHALL be cur_port+1, wrapping from NUM_PORTS-1 to 0.
REQ-022 In OFFER, grant_valid SHALL be 1, and grant_port and grant_len SHALL hold stable until grant_ready=1; the grant_ready cycle SHALL move the state to BUSY, with grant_valid=0 from the next cycle.
REQ-023 In BUSY, pkt_done=1 SHALL return the state to SCAN with cur_port unchanged and new_turn=0, so the same port is re-evaluated against its remaining deficit.
REQ-024 At most one grant SHALL be outstanding; grant_valid SHALL be 0 in SCAN and BUSY.
REQ-025 pkt_done outside BUSY, or grant_ready outside OFFER, SHALL be ignored functionally and pulse sched_err for one cycle.
REQ-026 quantum SHALL be sampled only when it is added (new_turn=1); a mid-turn change affects the next turn only.
REQ-027 A port with quantum=0 SHALL never be granted a packet with head_len>=1.
REQ-028 Grant latency SHALL be one cycle: grant_valid rises the cycle after the SCAN cycle that selected the port.

Reset
REQ-029 While sresetn=0: state=SCAN, cur_port=0, new_turn=1, all deficit=0, grant_valid=0, grant_port=0, grant_len=0, sched_err=0.
REQ-030 Reset asserted in OFFER or BUSY SHALL drop the grant with no pkt_done required; scanning restarts at port 0 on the first cycle after release.

Structure
REQ-031 p4_router_pkg SHALL hold enum ing_sched_state_t {SCAN, OFFER, BUSY} and the shared byte-length width constant used for LEN_WIDTH.
REQ-032 The block SHALL be a single module with no sub-module; the saturating add SHALL be a local function.

Verification (NUM_PORTS=4, all quantum=1500 unless stated)
REQ-033 Reset release, pkt_avail=4'b0100, head_len[2]=64 -> grant_valid=1, grant_port=2, grant_len=64 in the 4th cycle after release (ports 0,1 scanned empty); deficit[2]=1436.
REQ-034 quantum[0]=1000, only port 0 available, head_len=1500 held -> no grant on turn 1 (deficit 1000); granted on turn 2, remaining deficit 500.
REQ-035 Port 1 only, head_len=64, grant_ready=1, pkt_done 2 cycles after each accept -> 23 consecutive grants to port 1, deficit 28, then a new turn adds 1500.
REQ-036 Port 3 deficit 500, then pkt_avail[3]=0 at its next visit -> deficit[3]=0; quantum[0]=0 with pkt_avail[0]=1 -> port 0 never granted.
REQ-037 Grant offered and grant_ready held low for 10 cycles -> grant_valid, grant_port and grant_len stable for all 10; pkt_done pulsed in SCAN -> sched_err=1 for exactly one cycle, state unchanged.
REQ-038 sresetn=0 for 1 cycle while in BUSY -> all outputs 0 on the next cycle and all deficits 0; the first grant after release follows REQ-033 timing.
